// File: rtl/dmem_bus_adapter_if.sv
// Word-aligned on-chip data bus between the load/store adapter (master) and a slave.
interface dmem_bus_adapter_if;
   logic [31:0] BusAddr;
   logic [31:0] BusWData;
   logic [3:0]  BusBE;
   logic        BusWE;
   logic        BusValid;
   logic        BusReady;
   logic [31:0] BusRData;

   modport master (
      output BusAddr, BusWData, BusBE, BusWE, BusValid,
      input  BusReady, BusRData
   );

   modport slave (
      input  BusAddr, BusWData, BusBE, BusWE, BusValid,
      output BusReady, BusRData
   );
endinterface

// File: rtl/dmem_bus_adapter.sv
// RV32I load/store unit: turns one MEM-stage request into a single word-aligned bus
// transaction with byte enables, stalls through wait states and aligns/extends loads.
//
// state  | meaning
// IDLE   | sample request; flag misaligned/unsupported or launch transaction
// REQ    | BusValid high, waiting for BusReady or the timeout terminal count
// DONE   | present load result / timeout flag for one cycle, release the stall
module dmem_bus_adapter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [31:0]         AddressM,
   input  logic [31:0]         WriteDataM,
   input  logic                MemWriteM,
   input  logic                MemReadM,
   input  logic [2:0]          StrobeM,
   output logic [31:0]         ReadDataM,
   output logic                StallM,
   output logic                MisalignM,
   output logic                TimeoutErr,
   dmem_bus_adapter_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   localparam logic [9:0] TMR_LOAD = 10'(TIMEOUT - 1);

   state_t      r_state;
   logic [9:0]  r_tmr;
   logic [2:0]  r_strobe;
   logic [1:0]  r_lo;
   logic        r_load;
   logic        r_valid;
   logic        r_timeout_err;
   logic [31:0] r_read_data;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_we;

   logic        w_req;
   logic        w_bad;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   assign w_req = MemReadM | MemWriteM;

   always_comb begin
      w_bad   = 1'b0;
      w_be    = 4'b0000;
      w_wdata = WriteDataM;
      case (StrobeM)
         3'b000, 3'b100: begin
            w_be    = 4'b0001 << AddressM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
         end
         3'b001, 3'b101: begin
            w_be    = AddressM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
            w_bad   = AddressM[0];
         end
         3'b010: begin
            w_be  = 4'b1111;
            w_bad = |AddressM[1:0];
         end
         default: w_bad = 1'b1;
      endcase
   end

   always_comb begin
      w_byte = bus.BusRData[{r_lo, 3'b000} +: 8];
      w_half = bus.BusRData[{r_lo[1], 4'b0000} +: 16];
      case (r_strobe)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'h000000, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'h0000, w_half};
         default: w_ext = bus.BusRData;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= S_IDLE;
         r_tmr         <= '0;
         r_strobe      <= '0;
         r_lo          <= '0;
         r_load        <= 1'b0;
         r_valid       <= 1'b0;
         r_timeout_err <= 1'b0;
         r_read_data   <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_be          <= '0;
         r_we          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && !w_bad) begin
                  r_addr   <= {AddressM[31:2], 2'b00};
                  r_wdata  <= w_wdata;
                  r_be     <= w_be;
                  r_we     <= MemWriteM;
                  r_strobe <= StrobeM;
                  r_lo     <= AddressM[1:0];
                  r_load   <= MemReadM;
                  r_tmr    <= TMR_LOAD;
                  r_valid  <= 1'b1;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               // BusReady in the terminal-count cycle still completes normally
               if (bus.BusReady) begin
                  r_valid     <= 1'b0;
                  r_read_data <= r_load ? w_ext : 32'h0;
                  r_state     <= S_DONE;
               end else if (r_tmr == 10'd0) begin
                  r_valid       <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_read_data   <= 32'h0;
                  r_state       <= S_DONE;
               end else begin
                  r_tmr <= r_tmr - 10'd1;
               end
            end
            default: begin
               r_read_data   <= 32'h0;
               r_timeout_err <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign StallM     = r_valid | ((r_state == S_IDLE) & w_req & ~w_bad);
   assign MisalignM  = (r_state == S_IDLE) & w_req & w_bad;
   assign TimeoutErr = r_timeout_err;
   assign ReadDataM  = r_read_data;

   assign bus.BusAddr  = r_addr;
   assign bus.BusWData = r_wdata;
   assign bus.BusBE    = r_be;
   assign bus.BusWE    = r_we;
   assign bus.BusValid = r_valid;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter: per-cycle expectations come from a transaction-level
// model pushed into a queue and checked on every falling edge.
module tb_dmem_bus_adapter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_m, wdata_m, rdata_m;
   logic        we_m, re_m;
   logic [2:0]  strobe_m;
   logic        stall_m, mis_m, tmo_m;

   dmem_bus_adapter_if bus_if();

   dmem_bus_adapter #(.TIMEOUT(TMO)) dut (
      .CLK        (clk),
      .RST        (rst),
      .AddressM   (addr_m),
      .WriteDataM (wdata_m),
      .MemWriteM  (we_m),
      .MemReadM   (re_m),
      .StrobeM    (strobe_m),
      .ReadDataM  (rdata_m),
      .StallM     (stall_m),
      .MisalignM  (mis_m),
      .TimeoutErr (tmo_m),
      .bus        (bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, valid, mis, tmo;
      logic [31:0] rdata;
      int          mode;     // 0: bus regs unchecked, 1: in-flight request, 2: exact (reset)
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic        we;
   } exp_t;

   exp_t expq[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   cyc_no = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, expv);
   endtask

   // ---------------- transaction-level model ----------------
   function automatic int m_size(input logic [2:0] s);
      return (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic m_bad(input logic [2:0] s, input logic [31:0] a);
      if (!(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      return (int'(a[1:0]) % m_size(s)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
      int sz  = m_size(s);
      int off = int'(a[1:0]) / sz * sz;
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] wd);
      int sz = m_size(s);
      if (sz == 1) return {24'h0, wd[7:0]} * 32'h01010101;
      if (sz == 2) return {16'h0, wd[15:0]} * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] rd);
      int          sz   = m_size(s);
      int          off  = int'(a[1:0]) / sz * sz;
      logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      logic [31:0] v    = (rd >> (8 * off)) & mask;
      if (!s[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("StallM",     {31'b0, stall_m},          {31'b0, e.stall});
         chk("BusValid",   {31'b0, bus_if.BusValid},  {31'b0, e.valid});
         chk("MisalignM",  {31'b0, mis_m},            {31'b0, e.mis});
         chk("TimeoutErr", {31'b0, tmo_m},            {31'b0, e.tmo});
         chk("ReadDataM",  rdata_m,                   e.rdata);
         if (e.mode != 0) begin
            chk("BusAddr", bus_if.BusAddr,           e.addr);
            chk("BusBE",   {28'b0, bus_if.BusBE},    {28'b0, e.be});
            chk("BusWE",   {31'b0, bus_if.BusWE},    {31'b0, e.we});
            if (e.mode == 2 || e.we) chk("BusWData", bus_if.BusWData, e.wdata);
         end
      end
      cyc_no++;
   end

   // ---------------- stimulus helpers ----------------
   function automatic exp_t mk(input logic stall, valid, mis, tmo, input logic [31:0] rdata);
      exp_t e;
      e.stall = stall; e.valid = valid; e.mis = mis; e.tmo = tmo; e.rdata = rdata;
      e.mode = 0; e.addr = '0; e.wdata = '0; e.be = '0; e.we = 1'b0;
      return e;
   endfunction

   task automatic cyc(input exp_t e);
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic wr, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input logic abort);
      exp_t e;
      int   n;
      we_m = wr; re_m = ~wr; strobe_m = s; addr_m = a; wdata_m = wd;
      bus_if.BusReady = 1'b0; bus_if.BusRData = 32'h1357_9BDF;
      if (m_bad(s, a)) begin
         cyc(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
         return;
      end
      cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
      n = abort ? TMO : waits + 1;
      for (int i = 0; i < n; i++) begin
         bus_if.BusReady = (!abort && i == n - 1);
         bus_if.BusRData = (i == n - 1) ? rd : 32'hDEAD_BEEF;
         e = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         e.mode = 1; e.addr = {a[31:2], 2'b00}; e.be = m_be(s, a);
         e.we = wr; e.wdata = m_wdata(s, wd);
         cyc(e);
      end
      // stray BusReady outside REQ must be ignored; the request stays on the inputs
      bus_if.BusReady = 1'b1; bus_if.BusRData = 32'hA5A5_A5A5;
      cyc(mk(1'b0, 1'b0, 1'b0, abort, (wr || abort) ? 32'h0 : m_load(s, a, rd)));
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      e.mode = 2;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst = 1'b1; addr_m = '0; wdata_m = '0; we_m = 1'b0; re_m = 1'b0; strobe_m = '0;
      bus_if.BusReady = 1'b0; bus_if.BusRData = '0;

      // model pinned against hand-computed values
      chk("pin_be_sb",    {28'b0, m_be(3'b000, 32'h1003)},         32'h8);
      chk("pin_wd_sb",    m_wdata(3'b000, 32'h0000_00AB),          32'hABAB_ABAB);
      chk("pin_lh",       m_load(3'b001, 32'h2002, 32'h8001_1234), 32'hFFFF_8001);
      chk("pin_lhu",      m_load(3'b101, 32'h2002, 32'h8001_1234), 32'h0000_8001);
      chk("pin_lb",       m_load(3'b000, 32'h2001, 32'h0000_7F00), 32'h0000_007F);
      chk("pin_lbu",      m_load(3'b100, 32'h2003, 32'hFF00_0000), 32'h0000_00FF);
      chk("pin_bad_lw",   {31'b0, m_bad(3'b010, 32'h3002)},        32'h1);
      chk("pin_bad_011",  {31'b0, m_bad(3'b011, 32'h3000)},        32'h1);
      chk("pin_be_sh",    {28'b0, m_be(3'b001, 32'h1002)},         32'hC);

      @(posedge clk); #1;
      cyc(reset_exp());
      cyc(reset_exp());
      rst = 1'b0;
      cyc(reset_exp());

      access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,          0, 1'b0); // SB
      access(1'b0, 3'b001, 32'h0000_2002, 32'h0,          32'h8001_1234, 2, 1'b0); // LH
      access(1'b0, 3'b101, 32'h0000_2002, 32'h0,          32'h8001_1234, 0, 1'b0); // LHU
      access(1'b0, 3'b000, 32'h0000_2001, 32'h0,          32'h0000_7F00, 1, 1'b0); // LB
      access(1'b0, 3'b100, 32'h0000_2003, 32'h0,          32'hFF00_0000, 0, 1'b0); // LBU
      access(1'b0, 3'b010, 32'h0000_3002, 32'h0,          32'h0,          0, 1'b0); // LW misaligned
      access(1'b0, 3'b011, 32'h0000_3000, 32'h0,          32'h0,          0, 1'b0); // unsupported
      access(1'b1, 3'b001, 32'h0000_1002, 32'hCAFE_BEEF, 32'h0,          0, 1'b0); // SH upper half
      access(1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'h0,          0, 1'b1); // SW timeout
      access(1'b0, 3'b010, 32'h0000_6000, 32'h0,          32'hA5A5_0F0F, TMO - 1, 1'b0); // ready at last cycle
      access(1'b0, 3'b001, 32'h0000_2001, 32'h0,          32'h0,          0, 1'b0); // LH misaligned
      access(1'b1, 3'b100, 32'h0000_7002, 32'h0000_0155, 32'h0,          1, 1'b0); // SBU-coded store, lane 2

      // LW abandoned by reset in its second REQ cycle
      we_m = 1'b0; re_m = 1'b1; strobe_m = 3'b010; addr_m = 32'h0000_4000;
      bus_if.BusReady = 1'b0;
      cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
      e = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      e.mode = 1; e.addr = 32'h0000_4000; e.be = 4'hF; e.we = 1'b0;
      cyc(e);
      rst = 1'b1; re_m = 1'b0;
      cyc(e);
      rst = 1'b0;
      cyc(reset_exp());
      cyc(reset_exp());

      access(1'b0, 3'b000, 32'h0000_7000, 32'h0,          32'h0000_0080, 0, 1'b0); // LB negative
      we_m = 1'b0; re_m = 1'b0; bus_if.BusReady = 1'b0;
      cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

      @(negedge clk);
      n_tot++;
      if (expq.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, required 0", expq.size());

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
